// File: rtl/prd_com_filter.sv
// ---------------------------------------------------------------------------
// prd_com_filter
//   Input conditioning for the PRD command receiver board. Each raw active-low
//   optocoupler line is inverted, brought into the clk domain through a 2-FF
//   synchronizer and then passed through a tick-based integrating debouncer
//   with independent rise (ON_TICKS) and fall (OFF_TICKS) thresholds. The
//   clean active-high levels feed the iCom input of the PRD bus block.
//
// Ports
//   clk    in   1      system clock
//   iRes   in   1      asynchronous reset, active low
//   iComN  in   WIDTH  raw command inputs, active low, asynchronous to clk
//   oCom   out  WIDTH  debounced commands, active high, registered
//   oChg   out  1      one-clk pulse when at least one oCom bit changed
//   oTick  out  1      one-clk debounce sample strobe (debug)
// ---------------------------------------------------------------------------
module prd_com_filter #(
   parameter int WIDTH     = 16,
   parameter int CLOCK_IN  = 2_000_000,
   parameter int TICK_FREQ = 100_000,
   parameter int ON_TICKS  = 5,
   parameter int OFF_TICKS = 10
) (
   input  logic             clk,
   input  logic             iRes,
   input  logic [WIDTH-1:0] iComN,
   output logic [WIDTH-1:0] oCom,
   output logic             oChg,
   output logic             oTick
);

   localparam int TICK_DIV = CLOCK_IN / TICK_FREQ;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MAX_THR  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int CNT_W    = $clog2(MAX_THR + 1);

   localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

   // Count value at which the next differing sample flips the channel:
   // an inactive channel needs ON_TICKS samples, an active one OFF_TICKS.
   function automatic logic [CNT_W-1:0] last_cnt(input logic state);
      return state ? OFF_LAST : ON_LAST;
   endfunction

   logic [WIDTH-1:0] sync_p0;
   logic [WIDTH-1:0] sync_p1;
   logic [PRE_W-1:0] pre_cnt;
   logic             tick_now;
   logic [CNT_W-1:0] cnt     [WIDTH];
   logic [CNT_W-1:0] cnt_nxt [WIDTH];
   logic [WIDTH-1:0] com_nxt;

   // Stage p0/p1: invert to active-high and synchronize
   always_ff @(posedge clk or negedge iRes) begin
      if (!iRes) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= ~iComN;
         sync_p1 <= sync_p0;
      end
   end

   // Prescaler: the debouncers sample on the same edge that raises oTick
   assign tick_now = (pre_cnt == '0);

   always_ff @(posedge clk or negedge iRes) begin
      if (!iRes) begin
         pre_cnt <= PRE_LOAD;
         oTick   <= 1'b0;
      end else if (tick_now) begin
         pre_cnt <= PRE_LOAD;
         oTick   <= 1'b1;
      end else begin
         pre_cnt <= pre_cnt - PRE_W'(1);
         oTick   <= 1'b0;
      end
   end

   // Integrating debouncer: a sample matching the output clears the run,
   // a differing sample extends it, and the last one of the run flips the
   // output and clears the counter so it never exceeds the threshold.
   always_comb begin
      com_nxt = oCom;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = cnt[i];
         if (tick_now) begin
            if (sync_p1[i] == oCom[i]) begin
               cnt_nxt[i] = '0;
            end else if (cnt[i] == last_cnt(oCom[i])) begin
               com_nxt[i] = ~oCom[i];
               cnt_nxt[i] = '0;
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Stage p2: registered outputs
   always_ff @(posedge clk or negedge iRes) begin
      if (!iRes) begin
         oCom <= '0;
         oChg <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         oCom <= com_nxt;
         oChg <= (com_nxt != oCom);
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_prd_com_filter.sv
// ---------------------------------------------------------------------------
// tb_prd_com_filter
//   Self-checking bench for prd_com_filter (default parameters: 16 channels,
//   20-clk tick, 5 ticks to set, 10 ticks to clear). A cycle-level reference
//   model keeps, per channel, the history of debounce samples and flips its
//   output when the most recent thr samples all disagree with it; it is
//   compared with the DUT on every falling clock edge. Table-driven vectors
//   and hand sequences cover the reset, activation, glitch, release,
//   simultaneous and reset-mid-count cases, followed by random stimulus.
// ---------------------------------------------------------------------------
module tb_prd_com_filter;

   localparam int W    = 16;
   localparam int DIV  = 20;
   localparam int ON_T = 5;
   localparam int OFF_T = 10;

   logic         clk = 1'b0;
   logic         iRes;
   logic [W-1:0] iComN;
   logic [W-1:0] oCom;
   logic         oChg;
   logic         oTick;

   int n_checks = 0;
   int n_fail   = 0;

   prd_com_filter dut (
      .clk   (clk),
      .iRes  (iRes),
      .iComN (iComN),
      .oCom  (oCom),
      .oChg  (oChg),
      .oTick (oTick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] m_com  = '0;
   logic [W-1:0] m_s1   = '0;
   logic [W-1:0] m_s2   = '0;
   logic         m_chg  = 1'b0;
   logic         m_tick = 1'b0;
   int           m_edge = 0;
   logic [15:0]  m_hist [W];
   logic [W-1:0] m_samp;
   logic [15:0]  m_mask;

   always @(posedge clk or negedge iRes) begin
      if (!iRes) begin
         m_com  = '0;
         m_s1   = '0;
         m_s2   = '0;
         m_chg  = 1'b0;
         m_tick = 1'b0;
         m_edge = 0;
         for (int i = 0; i < W; i++) m_hist[i] = '0;
      end else begin
         m_samp = m_s2;
         m_s2   = m_s1;
         m_s1   = ~iComN;
         m_edge++;
         m_tick = (m_edge % DIV == 0);
         m_chg  = 1'b0;
         if (m_tick) begin
            for (int i = 0; i < W; i++) begin
               m_hist[i] = {m_hist[i][14:0], m_samp[i]};
               m_mask = (16'(1) << (m_com[i] ? OFF_T : ON_T)) - 16'(1);
               if ((!m_com[i] && ((m_hist[i] & m_mask) == m_mask)) ||
                   ( m_com[i] && ((m_hist[i] & m_mask) == 16'h0000))) begin
                  m_com[i] = ~m_com[i];
                  m_chg    = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("model_oCom",  32'(oCom),  32'(m_com));
      chk("model_oChg",  32'(oChg),  32'(m_chg));
      chk("model_oTick", 32'(oTick), 32'(m_tick));
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [W-1:0] comn;
      int           ticks;
      logic [W-1:0] exp_com;
      logic         exp_chg;
   } vec_t;

   vec_t vecs [13];

   task automatic sync_to_tick();
      bit found;
      found = 1'b0;
      for (int k = 0; k < 2 * DIV && !found; k++) begin
         @(posedge clk); #1;
         if (oTick) found = 1'b1;
      end
      chk("tick_sync", 32'(found), 32'(1));
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      int pulses;

      vecs[0]  = '{16'hFFFE, 4,  16'h0000, 1'b0};  // ch0 active, not yet
      vecs[1]  = '{16'hFFFE, 1,  16'h0001, 1'b1};  // 5th tick sets ch0
      vecs[2]  = '{16'hFFF6, 3,  16'h0001, 1'b0};  // ch3 low 3 ticks
      vecs[3]  = '{16'hFFFE, 1,  16'h0001, 1'b0};  // glitch rejected
      vecs[4]  = '{16'hFFF6, 4,  16'h0001, 1'b0};  // 4-tick low
      vecs[5]  = '{16'hFFFE, 1,  16'h0001, 1'b0};  // rejected again
      vecs[6]  = '{16'hFFF6, 5,  16'h0009, 1'b1};  // full 5 ticks sets ch3
      vecs[7]  = '{16'hFFFF, 9,  16'h0009, 1'b0};  // 9-tick release
      vecs[8]  = '{16'hFFF6, 1,  16'h0009, 1'b0};  // release aborted
      vecs[9]  = '{16'hFFFF, 10, 16'h0000, 1'b1};  // 10th tick clears both
      vecs[10] = '{16'hFFFF, 1,  16'h0000, 1'b0};
      vecs[11] = '{16'h0000, 5,  16'hFFFF, 1'b1};  // all channels together
      vecs[12] = '{16'h0000, 1,  16'hFFFF, 1'b0};

      // Reset held with random inputs
      iRes  = 1'b1;
      iComN = '1;
      #2 iRes = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         iComN = 16'($urandom);
         chk("rst_oCom",  32'(oCom),  32'(0));
         chk("rst_oChg",  32'(oChg),  32'(0));
         chk("rst_oTick", 32'(oTick), 32'(0));
      end
      iComN = '1;
      iRes  = 1'b1;

      // Tick spacing after release
      for (int p = 0; p < 2; p++) begin
         k = 0;
         do begin
            @(posedge clk); #1;
            k++;
         end while (!oTick && k <= 2 * DIV);
         chk(p == 0 ? "first_tick_delay" : "tick_period", 32'(k), 32'(DIV));
      end

      // Table: each row starts just after a tick edge
      for (int v = 0; v < 13; v++) begin
         iComN = vecs[v].comn;
         cycles(vecs[v].ticks * DIV);
         chk($sformatf("vec%0d_oCom", v),  32'(oCom),  32'(vecs[v].exp_com));
         chk($sformatf("vec%0d_oChg", v),  32'(oChg),  32'(vecs[v].exp_chg));
         chk($sformatf("vec%0d_oTick", v), 32'(oTick), 32'(1));
      end

      // Simultaneous flip of all channels: exactly one oChg pulse
      iComN = '1;
      cycles(11 * DIV);
      chk("simul_cleared", 32'(oCom), 32'(0));
      iComN  = '0;
      pulses = 0;
      for (int c = 0; c < 6 * DIV; c++) begin
         @(posedge clk); #1;
         if (oChg) begin
            pulses++;
            chk("simul_oCom_at_chg", 32'(oCom), 32'hFFFF);
         end
      end
      chk("simul_chg_pulses", 32'(pulses), 32'(1));
      chk("simul_oCom", 32'(oCom), 32'hFFFF);

      // Reset in the middle of a count on ch5
      iComN = '1;
      cycles(11 * DIV);
      chk("rmc_cleared", 32'(oCom), 32'(0));
      sync_to_tick();
      iComN = 16'hFFDF;
      cycles(3 * DIV);
      iRes = 1'b0;
      cycles(3);
      chk("rmc_in_reset", 32'(oCom), 32'(0));
      iRes = 1'b1;
      cycles(4 * DIV);
      chk("rmc_after_4", 32'(oCom), 32'(0));
      cycles(DIV);
      chk("rmc_after_5", 32'(oCom), 32'h0020);
      chk("rmc_chg", 32'(oChg), 32'(1));

      // Random stimulus against the model, with occasional resets
      for (int s = 0; s < 40; s++) begin
         iComN = 16'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            iRes = 1'b0;
            cycles(2);
            iRes = 1'b1;
         end
         cycles($urandom_range(1, 13 * DIV));
      end
      iComN = '0;
      cycles(6 * DIV);
      chk("rand_final_all_on", 32'(oCom), 32'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
